// File: rtl/imm_ctrl_pkg.sv
// Shared widths and state encoding for the ONC-16 immediate-operand controller.
package imm_ctrl_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_IMM_W   = 8;
    localparam int DEF_PFX_W   = DEF_DATA_W - DEF_IMM_W;

    typedef enum logic {
        IMM_ST_IDLE = 1'b0,
        IMM_ST_PFX  = 1'b1
    } imm_state_e;

endpackage

// File: rtl/imm_ctrl_ext.sv
// Immediate extender: presents both zero- and sign-extended forms of a field.
module imm_ctrl_ext #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_z_o,
    output logic [OUT_W-1:0] out_s_o
);

    assign out_z_o = {{(OUT_W-IN_W){1'b0}}, in_i};
    assign out_s_o = {{(OUT_W-IN_W){in_i[IN_W-1]}}, in_i};

endmodule

// File: rtl/imm_ctrl.sv
// Immediate-operand controller: extends decoded immediates or assembles them with
// a preceding PREFIX field, delivering a registered operand over a valid/ready link.
module imm_ctrl
    import imm_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMM_W  = DEF_IMM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_sext,
    input  logic              in_is_prefix,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_prefixed,
    output logic              err_dbl_prefix,
    output logic              dbg_state
);

    localparam int PFX_W = DATA_W - IMM_W;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high. in_ready depends only on the output register (free or being drained),
    // never on in_valid, and a flush cycle accepts nothing.
    imm_state_e        state_q;
    logic [PFX_W-1:0]  pfx_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_imm_q;
    logic              out_prefixed_q;
    logic              err_q;

    logic [DATA_W-1:0] ext_z;
    logic [DATA_W-1:0] ext_s;
    logic              accept;

    imm_ctrl_ext #(
        .IN_W  (IMM_W),
        .OUT_W (DATA_W)
    ) u_ext (
        .in_i    (in_imm),
        .out_z_o (ext_z),
        .out_s_o (ext_s)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IMM_ST_IDLE;
            pfx_q          <= '0;
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_prefixed_q <= 1'b0;
            err_q          <= 1'b0;
        end else if (flush) begin
            state_q     <= IMM_ST_IDLE;
            pfx_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            // A consumed operand drops valid unless a new one lands below.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                case (state_q)
                    IMM_ST_IDLE: begin
                        if (in_is_prefix) begin
                            pfx_q   <= in_imm[PFX_W-1:0];
                            state_q <= IMM_ST_PFX;
                        end else begin
                            out_imm_q      <= in_sext ? ext_s : ext_z;
                            out_prefixed_q <= 1'b0;
                            out_valid_q    <= 1'b1;
                        end
                    end
                    IMM_ST_PFX: begin
                        if (in_is_prefix) begin
                            pfx_q <= in_imm[PFX_W-1:0];
                            err_q <= 1'b1;
                        end else begin
                            out_imm_q      <= {pfx_q, in_imm};
                            out_prefixed_q <= 1'b1;
                            out_valid_q    <= 1'b1;
                            state_q        <= IMM_ST_IDLE;
                        end
                    end
                    default: state_q <= IMM_ST_IDLE;
                endcase
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_imm        = out_imm_q;
    assign out_prefixed   = out_prefixed_q;
    assign err_dbl_prefix = err_q;
    assign dbg_state      = state_q;

endmodule
